// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and 2-entry prefetch buffer between the RAM and decode,
// with redirect flush and halt-word stop.
module instr_fetch_unit #(
    parameter int DATA_SIZE = 32,
    parameter int ADDRESS_SIZE = 16,
    parameter logic [ADDRESS_SIZE-1:0] RESET_PC = '0,
    parameter logic [DATA_SIZE-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic                    mem_req,
    input  logic                    mem_gnt,
    output logic [ADDRESS_SIZE-1:0] mem_address,
    input  logic [DATA_SIZE-1:0]    fetch_in,
    input  logic                    redirect,
    input  logic [ADDRESS_SIZE-1:0] redirect_pc,
    output logic                    instr_valid,
    output logic [DATA_SIZE-1:0]    instr,
    output logic [ADDRESS_SIZE-1:0] instr_pc,
    input  logic                    instr_ready,
    output logic                    halted
);
    typedef enum logic {FETCH, HALTED} state_t;
    state_t state;
    logic [ADDRESS_SIZE-1:0] pc, pc0, pc1;
    logic [DATA_SIZE-1:0] word0, word1;
    logic [1:0] count;
    logic push, pop;
    assign mem_req = !reset && state == FETCH && count < 2'd2;
    assign push = mem_req && mem_gnt && !redirect;
    assign pop = instr_valid && instr_ready && !redirect;
    assign instr_valid = count != 2'd0;
    assign instr = word0;
    assign instr_pc = pc0;
    assign mem_address = pc;
    assign halted = state == HALTED;
    // Entry 0 is always the head; entry 1 shifts down on pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
            pc <= RESET_PC;
            count <= 2'd0;
            pc0 <= '0;
            pc1 <= '0;
            word0 <= '0;
            word1 <= '0;
        end else if (redirect) begin
            state <= FETCH;
            pc <= redirect_pc;
            count <= 2'd0;
        end else begin
            if (push) begin
                pc <= pc + ADDRESS_SIZE'(1);
                if (fetch_in == HALT_WORD) state <= HALTED;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
            if (push && (count == 2'd0 || pop)) begin
                word0 <= fetch_in;
                pc0 <= pc;
            end else if (pop) begin
                word0 <= word1;
                pc0 <= pc1;
            end
            if (push && count == 2'd1 && !pop) begin
                word1 <= fetch_in;
                pc1 <= pc;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: queue-based reference model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_instr_fetch_unit;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;
    logic clk = 0, reset = 1, mem_gnt = 0, redirect = 0, instr_ready = 0;
    logic [15:0] redirect_pc = 0;
    logic mem_req, instr_valid, halted;
    logic [15:0] mem_address, instr_pc;
    logic [31:0] instr, fetch_in;
    logic [31:0] ram [0:65535];
    int checks = 0, errors = 0;
    logic [47:0] q[$];
    logic [15:0] m_pc = 0;
    logic m_halted = 0, m_rst = 0, started = 0;

    always #5 clk = ~clk;
    assign fetch_in = ram[mem_address];

    instr_fetch_unit dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_address(mem_address), .fetch_in(fetch_in), .redirect(redirect),
        .redirect_pc(redirect_pc), .instr_valid(instr_valid), .instr(instr),
        .instr_pc(instr_pc), .instr_ready(instr_ready), .halted(halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) if (started) begin
        chk("mem_req", {31'b0, mem_req}, {31'b0, !reset && !m_halted && q.size() < 2});
        chk("mem_address", {16'b0, mem_address}, {16'b0, m_pc});
        chk("instr_valid", {31'b0, instr_valid}, {31'b0, q.size() != 0});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        if (q.size() != 0) begin
            chk("instr", instr, q[0][31:0]);
            chk("instr_pc", {16'b0, instr_pc}, {16'b0, q[0][47:32]});
        end else if (m_rst) begin
            chk("rst_instr", instr, 32'h0);
            chk("rst_instr_pc", {16'b0, instr_pc}, 32'h0);
        end
    end

    task automatic cyc(input logic r, input logic g, input logic rdy, input logic rd, input logic [15:0] rpc);
        logic [31:0] w;
        logic req, pop;
        reset = r; mem_gnt = g; instr_ready = rdy; redirect = rd; redirect_pc = rpc;
        @(posedge clk);
        m_rst = r;
        if (r) begin
            q.delete(); m_pc = 16'h0000; m_halted = 0;
        end else if (rd) begin
            q.delete(); m_pc = rpc; m_halted = 0;
        end else begin
            req = !m_halted && q.size() < 2;
            pop = q.size() != 0 && rdy;
            w = ram[m_pc];
            if (pop) void'(q.pop_front());
            if (req && g) begin
                q.push_back({m_pc, w});
                m_pc = m_pc + 16'd1;
                if (w == HALT) m_halted = 1;
            end
        end
        started = 1;
        @(negedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 32'h1000_0000 + i;
        // free run
        cyc(1, 1, 1, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("lit_rst_req", {31'b0, mem_req}, 32'h0);
        chk("lit_rst_addr", {16'b0, mem_address}, 32'h0);
        cyc(0, 1, 1, 0, 0);
        chk("lit_a", instr, 32'h1000_0000);
        chk("lit_a_addr", {16'b0, mem_address}, 32'h1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 0);
        chk("lit_d", instr, 32'h1000_0003);
        chk("lit_d_pc", {16'b0, instr_pc}, 32'h3);
        // backpressure
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 0);
        chk("lit_bp_req", {31'b0, mem_req}, 32'h0);
        chk("lit_bp_addr", {16'b0, mem_address}, 32'h2);
        chk("lit_bp_head", {16'b0, instr_pc}, 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 0);
        // grant loss
        for (int i = 0; i < 10; i++) cyc(0, i[0], 1, 0, 0);
        for (int i = 0; i < 10; i++) cyc(0, i[0], i[1], 0, 0);
        // redirect with full buffer
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        cyc(0, 1, 1, 1, 16'h0040);
        chk("lit_rd_valid", {31'b0, instr_valid}, 32'h0);
        chk("lit_rd_addr", {16'b0, mem_address}, 32'h40);
        chk("lit_rd_req", {31'b0, mem_req}, 32'h1);
        cyc(0, 1, 1, 0, 0);
        chk("lit_rd_pc", {16'b0, instr_pc}, 32'h40);
        // halt
        ram[2] = HALT;
        cyc(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 1, 0, 0);
        chk("lit_halted", {31'b0, halted}, 32'h1);
        chk("lit_halt_req", {31'b0, mem_req}, 32'h0);
        chk("lit_halt_addr", {16'b0, mem_address}, 32'h3);
        cyc(0, 1, 1, 1, 16'h0000);
        chk("lit_unhalt", {31'b0, halted}, 32'h0);
        chk("lit_unhalt_addr", {16'b0, mem_address}, 32'h0);
        for (int i = 0; i < 5; i++) cyc(0, 1, 1, 0, 0);
        ram[2] = 32'h1000_0002;
        // wrap
        cyc(0, 1, 1, 1, 16'hFFFF);
        cyc(0, 1, 1, 0, 0);
        chk("lit_wrap_ffff", {16'b0, instr_pc}, 32'hFFFF);
        cyc(0, 1, 1, 0, 0);
        chk("lit_wrap_0000", {16'b0, instr_pc}, 32'h0);
        // mid-run reset with full buffer
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0);
        cyc(1, 1, 1, 0, 0);
        chk("lit_mrst_valid", {31'b0, instr_valid}, 32'h0);
        chk("lit_mrst_addr", {16'b0, mem_address}, 32'h0);
        cyc(0, 1, 1, 0, 0);
        chk("lit_mrst_pc", {16'b0, instr_pc}, 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
